// File: rtl/des_pkg.sv
// des_pkg
// Shared definitions for the DES CBC front end and the DES core.
//   DES_BLK_W / DES_KEY_W : block and key widths (both 64)
//   state_t               : controller states UNINIT, READY, START, WAIT, OUT
//   cbc_text / cbc_result : chaining applied before and after the core
// Configuration macro used by the controller: DES_CBC_EN (CBC when defined,
// ECB only when undefined).
package des_pkg;

   localparam int DES_BLK_W = 64;
   localparam int DES_KEY_W = 64;

   typedef enum logic [2:0] {
      UNINIT = 3'd0,
      READY  = 3'd1,
      START  = 3'd2,
      WAIT   = 3'd3,
      OUT    = 3'd4
   } state_t;

   // Encryption folds the chaining value into the plaintext before the core.
   // Decryption hands the ciphertext to the core untouched.
   function automatic logic [DES_BLK_W-1:0] cbc_text(input logic [DES_BLK_W-1:0] blk,
                                                     input logic [DES_BLK_W-1:0] chain,
                                                     input logic               dec);
      return dec ? blk : (blk ^ chain);
   endfunction

   // Decryption removes the chaining value from the core result afterwards.
   function automatic logic [DES_BLK_W-1:0] cbc_result(input logic [DES_BLK_W-1:0] core,
                                                       input logic [DES_BLK_W-1:0] chain,
                                                       input logic               dec);
      return dec ? (core ^ chain) : core;
   endfunction

endpackage

// File: rtl/des_cbc_ctrl_if.sv
// des_cbc_ctrl_if
// Groups the stream handshakes and the DES core link of des_cbc_ctrl.
//   init    : i_fInit, i_fDec, i_Key, i_IV
//   input   : i_fValid, i_Block, o_fReady
//   output  : o_fValid, o_Block, i_fReady
//   core    : o_fStart, o_fDec, o_Key, o_Text, i_fDone, i_Text
// Signal names keep the controller's point of view (i_ = into controller).
//   slave  : the controller itself
//   master : the environment (upstream, downstream and core)
// i_IV is only consumed when DES_CBC_EN is defined.
interface des_cbc_ctrl_if;
   import des_pkg::*;

   logic                 i_fInit;
   logic                 i_fDec;
   logic [DES_KEY_W-1:0] i_Key;
   logic [DES_BLK_W-1:0] i_IV;
   logic                 i_fValid;
   logic [DES_BLK_W-1:0] i_Block;
   logic                 o_fReady;
   logic                 o_fValid;
   logic [DES_BLK_W-1:0] o_Block;
   logic                 i_fReady;
   logic                 o_fStart;
   logic                 o_fDec;
   logic [DES_KEY_W-1:0] o_Key;
   logic [DES_BLK_W-1:0] o_Text;
   logic                 i_fDone;
   logic [DES_BLK_W-1:0] i_Text;

   modport slave (
      input  i_fInit, i_fDec, i_Key, i_IV,
      input  i_fValid, i_Block,
      output o_fReady,
      output o_fValid, o_Block,
      input  i_fReady,
      output o_fStart, o_fDec, o_Key, o_Text,
      input  i_fDone, i_Text
   );

   modport master (
      output i_fInit, i_fDec, i_Key, i_IV,
      output i_fValid, i_Block,
      input  o_fReady,
      input  o_fValid, o_Block,
      output i_fReady,
      input  o_fStart, o_fDec, o_Key, o_Text,
      output i_fDone, i_Text
   );

endinterface

// File: rtl/des_cbc_ctrl.sv
// des_cbc_ctrl
// Block-chaining front end for the iterative DES core. Takes one 64-bit block
// at a time from a valid/ready stream, applies CBC chaining, starts the core,
// captures its single-cycle done result and holds it on a backpressured
// output stream. Key, IV/chain and mode live here so the core stays a pure
// single-block engine.
// Ports:
//   i_Clk  : clock, rising edge
//   i_Rst  : asynchronous active-low reset (shared with the DES core)
//   ctrl   : des_cbc_ctrl_if.slave (init, in/out streams, core link)
// Configuration:
//   DES_CBC_EN defined   : CBC chaining (chain and save registers built)
//   DES_CBC_EN undefined : ECB only, i_IV unused, blocks pass to/from the
//                          core unchanged; i_fInit still loads key and mode
module des_cbc_ctrl
   import des_pkg::*;
(
   input  logic          i_Clk,
   input  logic          i_Rst,
   des_cbc_ctrl_if.slave ctrl
);

   state_t               state;
   logic [DES_KEY_W-1:0] key_reg;
   logic                 mode_reg;
   logic [DES_BLK_W-1:0] text_reg;
   logic [DES_BLK_W-1:0] out_reg;
   logic                 start_reg;
   logic                 valid_reg;

`ifdef DES_CBC_EN
   // chain_reg holds the previous ciphertext (or the IV); save_reg keeps the
   // incoming ciphertext during decryption so it can become the next chain.
   logic [DES_BLK_W-1:0] chain_reg;
   logic [DES_BLK_W-1:0] save_reg;
`else
   logic unused_iv;
   assign unused_iv = ^ctrl.i_IV;
`endif

   // Init takes priority over a block offered in the same cycle, so the
   // ready output drops whenever i_fInit is high.
   assign ctrl.o_fReady = (state == READY) && !ctrl.i_fInit;

   assign ctrl.o_fValid = valid_reg;
   assign ctrl.o_Block  = out_reg;
   assign ctrl.o_fStart = start_reg;
   assign ctrl.o_fDec   = mode_reg;
   assign ctrl.o_Key    = key_reg;
   assign ctrl.o_Text   = text_reg;

   // Single-block sequencer: UNINIT waits for the first key load, READY
   // accepts a block, START pulses the core for one cycle, WAIT catches the
   // done pulse, OUT holds the result until the downstream takes it.
   always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
         state     <= UNINIT;
         key_reg   <= '0;
         mode_reg  <= 1'b0;
         text_reg  <= '0;
         out_reg   <= '0;
         start_reg <= 1'b0;
         valid_reg <= 1'b0;
`ifdef DES_CBC_EN
         chain_reg <= '0;
         save_reg  <= '0;
`endif
      end else begin
         case (state)
            UNINIT: begin
               if (ctrl.i_fInit) begin
                  key_reg  <= ctrl.i_Key;
                  mode_reg <= ctrl.i_fDec;
`ifdef DES_CBC_EN
                  chain_reg <= ctrl.i_IV;
`endif
                  state    <= READY;
               end
            end

            READY: begin
               if (ctrl.i_fInit) begin
                  key_reg  <= ctrl.i_Key;
                  mode_reg <= ctrl.i_fDec;
`ifdef DES_CBC_EN
                  chain_reg <= ctrl.i_IV;
`endif
               end else if (ctrl.i_fValid) begin
`ifdef DES_CBC_EN
                  text_reg <= cbc_text(ctrl.i_Block, chain_reg, mode_reg);
                  save_reg <= ctrl.i_Block;
`else
                  text_reg <= ctrl.i_Block;
`endif
                  start_reg <= 1'b1;
                  state     <= START;
               end
            end

            START: begin
               start_reg <= 1'b0;
               state     <= WAIT;
            end

            WAIT: begin
               if (ctrl.i_fDone) begin
`ifdef DES_CBC_EN
                  out_reg   <= cbc_result(ctrl.i_Text, chain_reg, mode_reg);
                  chain_reg <= mode_reg ? save_reg : ctrl.i_Text;
`else
                  out_reg   <= ctrl.i_Text;
`endif
                  valid_reg <= 1'b1;
                  state     <= OUT;
               end
            end

            OUT: begin
               if (ctrl.i_fReady) begin
                  valid_reg <= 1'b0;
                  state     <= READY;
               end
            end

            default: begin
               start_reg <= 1'b0;
               valid_reg <= 1'b0;
               state     <= UNINIT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_des_cbc_ctrl.sv
// tb_des_cbc_ctrl
// Directed bench for des_cbc_ctrl. A behavioural stand-in for the DES core
// answers each start pulse with a done pulse 17 cycles later. The stand-in
// returns the published DES answer for key 133457799BBCDFF1 / block
// 0123456789ABCDEF and an invertible toy cipher for every other input, which
// is enough to observe chaining. Expectations follow DES_CBC_EN (CBC when
// defined, ECB otherwise).
module tb_des_cbc_ctrl;
   import des_pkg::*;

   localparam logic [63:0] K1       = 64'h133457799BBCDFF1;
   localparam logic [63:0] VEC_P    = 64'h0123456789ABCDEF;
   localparam logic [63:0] VEC_C    = 64'h85E813540F0AB405;
   localparam logic [63:0] IV2      = 64'hFEDCBA9876543210;
   localparam logic [63:0] TOY_MASK = 64'hA5A5_3C3C_0F0F_9696;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;
   int   start_count;
   int   valid_count;
   int   core_cnt;
   logic [63:0] core_res;

   logic [63:0] m_key;
   logic [63:0] m_chain;
   logic        m_dec;

   des_cbc_ctrl_if bus();

   des_cbc_ctrl dut (
      .i_Clk (clk),
      .i_Rst (rst_n),
      .ctrl  (bus)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in core cipher: known DES vector plus a reversible toy mapping.
   function automatic logic [63:0] coreEnc(input logic [63:0] k, input logic [63:0] x);
      logic [63:0] t;
      if (k == K1 && x == VEC_P) return VEC_C;
      t = x ^ k;
      return {t[50:0], t[63:51]} ^ TOY_MASK;
   endfunction

   function automatic logic [63:0] coreDec(input logic [63:0] k, input logic [63:0] y);
      logic [63:0] t;
      if (k == K1 && y == VEC_C) return VEC_P;
      t = y ^ TOY_MASK;
      return {t[12:0], t[63:13]} ^ k;
   endfunction

   // Core stand-in: start sampled at one edge, done high 16 edges later,
   // which puts done in cycle accept+18. Shares the controller reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_cnt     <= 0;
         core_res     <= '0;
         bus.i_fDone  <= 1'b0;
         bus.i_Text   <= '0;
      end else begin
         bus.i_fDone <= 1'b0;
         bus.i_Text  <= '0;
         if (bus.o_fStart) begin
            core_cnt <= 16;
            core_res <= bus.o_fDec ? coreDec(bus.o_Key, bus.o_Text)
                                   : coreEnc(bus.o_Key, bus.o_Text);
         end else if (core_cnt == 1) begin
            core_cnt    <= 0;
            bus.i_fDone <= 1'b1;
            bus.i_Text  <= core_res;
         end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   // Event counters for start pulses and output-valid cycles.
   always @(posedge clk) begin
      if (bus.o_fStart) start_count <= start_count + 1;
      if (bus.o_fValid) valid_count <= valid_count + 1;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected controller behaviour for one block, from the model state.
   function automatic logic [63:0] mdlText(input logic [63:0] blk);
`ifdef DES_CBC_EN
      return m_dec ? blk : (blk ^ m_chain);
`else
      return blk;
`endif
   endfunction

   function automatic logic [63:0] mdlOut(input logic [63:0] blk);
      logic [63:0] core;
      core = m_dec ? coreDec(m_key, mdlText(blk)) : coreEnc(m_key, mdlText(blk));
`ifdef DES_CBC_EN
      return m_dec ? (core ^ m_chain) : core;
`else
      return core;
`endif
   endfunction

   task automatic doInit(input logic [63:0] key, input logic [63:0] iv, input logic dec);
      @(negedge clk);
      bus.i_fInit = 1'b1;
      bus.i_Key   = key;
      bus.i_IV    = iv;
      bus.i_fDec  = dec;
      #1;
      checkOutput("init_rdy", bus.o_fReady, 1'b0);
      @(negedge clk);
      bus.i_fInit = 1'b0;
      m_key   = key;
      m_chain = iv;
      m_dec   = dec;
      checkOutput("init_key", bus.o_Key, key);
      checkOutput("init_dec", bus.o_fDec, dec);
   endtask

   // Offers one block, checks the core link and latency, stalls the output
   // for 'stall' cycles, then takes it. Returns the observed output block.
   task automatic applyStimulus(input logic [63:0] blk, input int stall,
                                input string tag, output logic [63:0] got);
      logic [63:0] exp_text;
      logic [63:0] exp_out;
      int          starts_before;
      int          lat;
      exp_text = mdlText(blk);
      exp_out  = mdlOut(blk);
      @(negedge clk);
      bus.i_fValid = 1'b1;
      bus.i_Block  = blk;
      bus.i_fReady = 1'b0;
      #1;
      checkOutput({tag, "_rdy"}, bus.o_fReady, 1'b1);
      starts_before = start_count;
      @(negedge clk);
      bus.i_fValid = 1'b0;
      checkOutput({tag, "_start"}, bus.o_fStart, 1'b1);
      checkOutput({tag, "_text"}, bus.o_Text, exp_text);
      checkOutput({tag, "_key"}, bus.o_Key, m_key);
      checkOutput({tag, "_mode"}, bus.o_fDec, m_dec);
      lat = 1;
      while (!bus.o_fValid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      checkOutput({tag, "_lat"}, lat, 19);
      checkOutput({tag, "_blk"}, bus.o_Block, exp_out);
      got = bus.o_Block;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         checkOutput({tag, "_hold_v"}, bus.o_fValid, 1'b1);
         checkOutput({tag, "_hold_b"}, bus.o_Block, exp_out);
      end
      bus.i_fReady = 1'b1;
      @(negedge clk);
      bus.i_fReady = 1'b0;
      checkOutput({tag, "_taken"}, bus.o_fValid, 1'b0);
      checkOutput({tag, "_back_rdy"}, bus.o_fReady, 1'b1);
      checkOutput({tag, "_nstart"}, start_count, starts_before + 1);
`ifdef DES_CBC_EN
      m_chain = m_dec ? blk : exp_out;
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] got;
      logic [63:0] c1;
      logic [63:0] c2;
      int          sc;
      int          vc;

      tests = 0;
      fails = 0;
      start_count = 0;
      valid_count = 0;
      m_key = '0;
      m_chain = '0;
      m_dec = 1'b0;
      rst_n        = 1'b0;
      bus.i_fInit  = 1'b0;
      bus.i_fDec   = 1'b0;
      bus.i_Key    = '0;
      bus.i_IV     = '0;
      bus.i_fValid = 1'b1;
      bus.i_Block  = VEC_P;
      bus.i_fReady = 1'b0;

      // Reset with a block offered: nothing accepted, every output zero.
      @(negedge clk);
      checkOutput("rst_rdy",   bus.o_fReady, 1'b0);
      checkOutput("rst_valid", bus.o_fValid, 1'b0);
      checkOutput("rst_start", bus.o_fStart, 1'b0);
      checkOutput("rst_block", bus.o_Block, 64'h0);
      checkOutput("rst_key",   bus.o_Key, 64'h0);
      checkOutput("rst_text",  bus.o_Text, 64'h0);
      checkOutput("rst_dec",   bus.o_fDec, 1'b0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      checkOutput("uninit_rdy",   bus.o_fReady, 1'b0);
      checkOutput("uninit_start", start_count, 0);
      checkOutput("uninit_key",   bus.o_Key, 64'h0);
      bus.i_fValid = 1'b0;

      // Known-answer encryption with a zero IV.
      doInit(K1, 64'h0, 1'b0);
      applyStimulus(VEC_P, 0, "kat", got);
      checkOutput("kat_hand", got, VEC_C);

      // Two identical plaintext blocks under IV = plaintext.
      doInit(K1, VEC_P, 1'b0);
      applyStimulus(VEC_P, 0, "cbc1", c1);
      applyStimulus(VEC_P, 0, "cbc2", c2);

      // Decrypt them again; the first output is stalled for 5 cycles.
      doInit(K1, VEC_P, 1'b1);
      applyStimulus(c1, 5, "dec1", got);
      checkOutput("dec1_hand", got, VEC_P);
      applyStimulus(c2, 0, "dec2", got);
      checkOutput("dec2_hand", got, VEC_P);

      // Init and valid together: init wins, no start, new IV applies next.
      sc = start_count;
      @(negedge clk);
      bus.i_fInit  = 1'b1;
      bus.i_Key    = K1;
      bus.i_IV     = IV2;
      bus.i_fDec   = 1'b0;
      bus.i_fValid = 1'b1;
      bus.i_Block  = VEC_P;
      #1;
      checkOutput("both_rdy", bus.o_fReady, 1'b0);
      @(negedge clk);
      bus.i_fInit  = 1'b0;
      bus.i_fValid = 1'b0;
      m_key   = K1;
      m_chain = IV2;
      m_dec   = 1'b0;
      checkOutput("both_nostart", bus.o_fStart, 1'b0);
      checkOutput("both_count",   start_count, sc);
      checkOutput("both_mode",    bus.o_fDec, 1'b0);
      applyStimulus(VEC_P, 0, "newiv", got);

      // Reset while the core is busy: block discarded, back in UNINIT.
      @(negedge clk);
      bus.i_fValid = 1'b1;
      bus.i_Block  = VEC_P;
      @(negedge clk);
      bus.i_fValid = 1'b0;
      repeat (6) @(negedge clk);
      vc = valid_count;
      rst_n = 1'b0;
      #1;
      checkOutput("wrst_valid", bus.o_fValid, 1'b0);
      checkOutput("wrst_start", bus.o_fStart, 1'b0);
      checkOutput("wrst_key",   bus.o_Key, 64'h0);
      checkOutput("wrst_text",  bus.o_Text, 64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sc = start_count;
      bus.i_fValid = 1'b1;
      repeat (25) @(negedge clk);
      bus.i_fValid = 1'b0;
      checkOutput("wrst_rdy",    bus.o_fReady, 1'b0);
      checkOutput("wrst_nvalid", valid_count, vc);
      checkOutput("wrst_nstart", start_count, sc);

      // Re-init and encrypt the known answer again.
      doInit(K1, 64'h0, 1'b0);
      applyStimulus(VEC_P, 0, "reinit", got);
      checkOutput("reinit_hand", got, VEC_C);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
